// File: rtl/seq_stim_gen.sv
// Start/a/b/stop transaction sequencer feeding the sequence-composition checker.
// One-deep request buffering, abort, sticky overrun and a wrapping completion counter.
module seq_stim_gen #(
  parameter int A_DELAY  = 1,
  parameter int STOP_GAP = 2,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic             abort,
  input  logic             clr_err,
  output logic             start,
  output logic             b,
  output logic             a,
  output logic             stop,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic             overrun,
  output logic [CNT_W-1:0] txn_count
);

  if (A_DELAY < 1 || A_DELAY > STOP_GAP || STOP_GAP > 15) begin : g_param_err
    $error("seq_stim_gen: need 1 <= A_DELAY <= STOP_GAP <= 15");
  end

  localparam logic [3:0] A_PH    = 4'(A_DELAY);
  localparam logic [3:0] STOP_PH = 4'(STOP_GAP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_ph;
  logic [3:0]       w_ph_nxt;
  logic             r_req_q;
  logic             r_pending;
  logic             w_pending_nxt;
  logic             r_overrun;
  logic             w_overrun_nxt;
  logic [CNT_W-1:0] r_txn_count;
  logic             w_req_edge;
  logic             w_abort_take;
  logic             w_drop;
  logic             w_txn_inc;

  logic r_start, r_b, r_a, r_stop, r_busy, r_done, r_aborted;
  logic w_start_nxt, w_b_nxt, w_a_nxt, w_stop_nxt, w_busy_nxt, w_done_nxt;

  assign w_req_edge   = req & ~r_req_q;
  assign w_abort_take = abort & ((r_state == S_START) || (r_state == S_RUN));
  assign w_txn_inc    = (r_state == S_RUN) && (w_state_nxt == S_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ph    <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_ph    <= w_ph_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ph_nxt    = 4'd0;
    case (r_state)
      S_IDLE: begin
        if (w_req_edge || r_pending) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_START: begin
        if (w_abort_take) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_abort_take) begin
          w_state_nxt = S_IDLE;
        end else if (r_ph == STOP_PH) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_RUN;
          w_ph_nxt    = r_ph + 4'd1;
        end
      end
      S_DONE: begin
        if (r_pending) begin
          w_state_nxt = S_START;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // A request edge in DONE with a buffered request already waiting is dropped,
  // even though that buffered request is consumed on the same edge.
  always_comb begin
    w_pending_nxt = r_pending;
    w_drop        = 1'b0;
    if (w_abort_take) begin
      w_pending_nxt = 1'b0;
    end else if (r_state == S_IDLE) begin
      w_pending_nxt = 1'b0;
    end else begin
      w_drop = w_req_edge & r_pending;
      if (w_req_edge && !r_pending) begin
        w_pending_nxt = 1'b1;
      end else if (r_state == S_DONE) begin
        w_pending_nxt = 1'b0;
      end else begin
        w_pending_nxt = r_pending;
      end
    end
    if (w_drop) begin
      w_overrun_nxt = 1'b1;
    end else if (clr_err) begin
      w_overrun_nxt = 1'b0;
    end else begin
      w_overrun_nxt = r_overrun;
    end
  end

  always_comb begin
    w_start_nxt = 1'b0;
    w_b_nxt     = 1'b0;
    w_a_nxt     = 1'b0;
    w_stop_nxt  = 1'b0;
    w_busy_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    case (w_state_nxt)
      S_START: begin
        w_start_nxt = 1'b1;
        w_busy_nxt  = 1'b1;
      end
      S_RUN: begin
        w_b_nxt    = 1'b1;
        w_a_nxt    = (w_ph_nxt == A_PH);
        w_stop_nxt = (w_ph_nxt == STOP_PH);
        w_busy_nxt = 1'b1;
      end
      S_DONE: begin
        w_done_nxt = 1'b1;
        w_busy_nxt = 1'b1;
      end
      default: w_busy_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q     <= 1'b0;
      r_pending   <= 1'b0;
      r_overrun   <= 1'b0;
      r_txn_count <= {CNT_W{1'b0}};
    end else begin
      r_req_q   <= req;
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
      if (w_txn_inc) begin
        r_txn_count <= r_txn_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start   <= 1'b0;
      r_b       <= 1'b0;
      r_a       <= 1'b0;
      r_stop    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      r_start   <= w_start_nxt;
      r_b       <= w_b_nxt;
      r_a       <= w_a_nxt;
      r_stop    <= w_stop_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_aborted <= w_abort_take;
    end
  end

  assign start     = r_start;
  assign b         = r_b;
  assign a         = r_a;
  assign stop      = r_stop;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign overrun   = r_overrun;
  assign txn_count = r_txn_count;

endmodule

// File: tb/tb_seq_stim_gen.sv
// Scoreboard bench for seq_stim_gen: default timing plus an A_DELAY=STOP_GAP=4 instance.
module tb_seq_stim_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req = 1'b0, abort = 1'b0, clr_err = 1'b0, req4 = 1'b0;
  logic start, b, a, stop, busy, done, aborted, overrun;
  logic [7:0] txn_count;
  logic start4, b4, a4, stop4, busy4, done4, aborted4, overrun4;
  logic [7:0] txn_count4;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic fin = 1'b0;

  typedef struct packed {
    int         cyc;
    logic [7:0] fl;   // {start,b,a,stop,busy,done,aborted,overrun}
    logic [7:0] cnt;
  } rec_t;

  rec_t ev_q[$];
  rec_t ev4_q[$];
  rec_t st_q[$];

  localparam logic [7:0] F_0  = 8'b0000_0000;
  localparam logic [7:0] F_ST = 8'b1000_1000;
  localparam logic [7:0] F_B  = 8'b0100_1000;
  localparam logic [7:0] F_A  = 8'b0110_1000;
  localparam logic [7:0] F_SP = 8'b0101_1000;
  localparam logic [7:0] F_AS = 8'b0111_1000;
  localparam logic [7:0] F_DN = 8'b0000_1100;
  localparam logic [7:0] F_AB = 8'b0000_0010;
  localparam logic [7:0] F_OV = 8'b0000_0001;

  seq_stim_gen u_dut (
    .clk(clk), .rst(rst), .req(req), .abort(abort), .clr_err(clr_err),
    .start(start), .b(b), .a(a), .stop(stop), .busy(busy), .done(done),
    .aborted(aborted), .overrun(overrun), .txn_count(txn_count)
  );

  seq_stim_gen #(.A_DELAY(4), .STOP_GAP(4), .CNT_W(8)) u_dut4 (
    .clk(clk), .rst(rst), .req(req4), .abort(1'b0), .clr_err(1'b0),
    .start(start4), .b(b4), .a(a4), .stop(stop4), .busy(busy4), .done(done4),
    .aborted(aborted4), .overrun(overrun4), .txn_count(txn_count4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk(int c, logic [7:0] f, logic [7:0] n);
    rec_t r;
    r.cyc = c;
    r.fl  = f;
    r.cnt = n;
    return r;
  endfunction

  task automatic cmp(string nm, rec_t got, rec_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got flags %b cnt %0d, expected cycle %0d flags %b cnt %0d",
               nm, got.cyc, got.fl, got.cnt, exp.cyc, exp.fl, exp.cnt);
    end
  endtask

  task automatic leftover(string nm, rec_t e);
    checks++;
    errors++;
    $display("FAIL %s cycle %0d: expected flags %b cnt %0d never seen", nm, e.cyc, e.fl, e.cnt);
  endtask

  // Monitor: compares every pulse cycle and every scheduled status cycle.
  initial begin
    rec_t o, o4, e;
    forever begin
      @(negedge clk);
      o  = mk(cyc, {start, b, a, stop, busy, done, aborted, overrun}, txn_count);
      o4 = mk(cyc, {start4, b4, a4, stop4, busy4, done4, aborted4, overrun4}, txn_count4);
      if (fin) begin
        while (ev_q.size() > 0)  leftover("ev_missing",  ev_q.pop_front());
        while (ev4_q.size() > 0) leftover("ev4_missing", ev4_q.pop_front());
        while (st_q.size() > 0)  leftover("st_missing",  st_q.pop_front());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
      if (start | a | stop | done | aborted) begin
        if (ev_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ev_unexpected cycle %0d: got flags %b cnt %0d, expected no pulse", cyc, o.fl, o.cnt);
        end else begin
          e = ev_q.pop_front();
          cmp("ev", o, e);
        end
      end
      if (start4 | a4 | stop4 | done4 | aborted4) begin
        if (ev4_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ev4_unexpected cycle %0d: got flags %b cnt %0d, expected no pulse", cyc, o4.fl, o4.cnt);
        end else begin
          e = ev4_q.pop_front();
          cmp("ev4", o4, e);
        end
      end
      while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
        e = st_q.pop_front();
        cmp("status", o, e);
      end
    end
  end

  task automatic exp_std(int k, logic [7:0] c0, logic ov_a, logic ov_d);
    ev_q.push_back(mk(k,     F_ST | {7'b0, ov_a}, c0));
    ev_q.push_back(mk(k + 2, F_A  | {7'b0, ov_a}, c0));
    ev_q.push_back(mk(k + 3, F_SP | {7'b0, ov_a}, c0));
    ev_q.push_back(mk(k + 4, F_DN | {7'b0, ov_d}, c0 + 8'd1));
  endtask

  task automatic wait_cyc(int n);
    while (cyc < n) @(negedge clk);
  endtask

  // Stimulus: every expectation targets a cycle after the current one.
  initial begin
    int k;
    @(negedge clk);
    st_q.push_back(mk(cyc + 1, F_0, 8'd0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single default transaction
    req = 1'b1; k = cyc + 1;
    exp_std(k, 8'd0, 1'b0, 1'b0);
    st_q.push_back(mk(k + 1, F_B, 8'd0));
    st_q.push_back(mk(k + 5, F_0, 8'd1));
    @(negedge clk); req = 1'b0;
    wait_cyc(k + 6);

    // Pending request at k+2, dropped request at k+4, then clr_err
    req = 1'b1; k = cyc + 1;
    exp_std(k,     8'd1, 1'b0, 1'b1);
    exp_std(k + 5, 8'd2, 1'b1, 1'b1);
    st_q.push_back(mk(k + 4,  F_DN | F_OV, 8'd2));
    st_q.push_back(mk(k + 10, F_OV, 8'd3));
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0;
    wait_cyc(k + 10);
    clr_err = 1'b1;
    st_q.push_back(mk(k + 11, F_0, 8'd3));
    @(negedge clk); clr_err = 1'b0;
    wait_cyc(k + 12);

    // Abort at k+2 with a simultaneous request edge: request discarded
    req = 1'b1; k = cyc + 1;
    ev_q.push_back(mk(k,     F_ST, 8'd3));
    ev_q.push_back(mk(k + 2, F_AB, 8'd3));
    st_q.push_back(mk(k + 4, F_0, 8'd3));
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1; abort = 1'b1;
    @(negedge clk); req = 1'b0; abort = 1'b0;
    wait_cyc(k + 8);

    // Pending set at k+2, abort at k+3 clears it: no stop, no relaunch
    req = 1'b1; k = cyc + 1;
    ev_q.push_back(mk(k,     F_ST, 8'd3));
    ev_q.push_back(mk(k + 2, F_A,  8'd3));
    ev_q.push_back(mk(k + 3, F_AB, 8'd3));
    st_q.push_back(mk(k + 9, F_0, 8'd3));
    @(negedge clk); req = 1'b0;
    @(negedge clk); req = 1'b1;
    @(negedge clk); req = 1'b0; abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    wait_cyc(k + 10);

    // A_DELAY = STOP_GAP = 4: a and stop coincide at k+5
    req4 = 1'b1; k = cyc + 1;
    ev4_q.push_back(mk(k,     F_ST, 8'd0));
    ev4_q.push_back(mk(k + 5, F_AS, 8'd0));
    ev4_q.push_back(mk(k + 6, F_DN, 8'd1));
    @(negedge clk); req4 = 1'b0;
    wait_cyc(k + 8);

    // Asynchronous reset in the first RUN cycle
    req = 1'b1; k = cyc + 1;
    ev_q.push_back(mk(k, F_ST, 8'd3));
    st_q.push_back(mk(k + 1, F_0, 8'd0));
    @(negedge clk); req = 1'b0;
    @(posedge clk); #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // 256 transactions from a fresh reset: counter wraps back to 0
    for (int i = 0; i < 256; i++) begin
      req = 1'b1; k = cyc + 1;
      exp_std(k, 8'(i), 1'b0, 1'b0);
      @(negedge clk); req = 1'b0;
      wait_cyc(k + 5);
    end
    st_q.push_back(mk(cyc + 1, F_0, 8'd0));
    repeat (3) @(negedge clk);

    fin = 1'b1;
    repeat (5) @(negedge clk);
    $display("FAIL monitor_end: monitor did not close the run");
    $fatal(1);
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, checks %0d", checks);
    $fatal(1);
  end

endmodule
